// File: rtl/mips_instr_encoder_pkg.sv
// rtl/mips_instr_encoder_pkg.sv - shared instruction classes, opcodes and funct codes
// Shared with the control decoders so encode and decode agree by construction.
package mips_instr_encoder_pkg;

  typedef enum logic [3:0] {
    CLS_ADD  = 4'd0,
    CLS_SUB  = 4'd1,
    CLS_AND  = 4'd2,
    CLS_OR   = 4'd3,
    CLS_SLT  = 4'd4,
    CLS_LW   = 4'd5,
    CLS_SW   = 4'd6,
    CLS_BEQ  = 4'd7,
    CLS_ADDI = 4'd8,
    CLS_J    = 4'd9
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'b0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_field_pack.sv
// rtl/mips_field_pack.sv - combinational class/field to 32-bit MIPS word packer
module mips_field_pack
  import mips_instr_encoder_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (instr_class_e'(cls))
      CLS_ADD:  word = rtype(rs, rt, rd, FN_ADD);
      CLS_SUB:  word = rtype(rs, rt, rd, FN_SUB);
      CLS_AND:  word = rtype(rs, rt, rd, FN_AND);
      CLS_OR:   word = rtype(rs, rt, rd, FN_OR);
      CLS_SLT:  word = rtype(rs, rt, rd, FN_SLT);
      CLS_LW:   word = itype(OP_LW, rs, rt, imm);
      CLS_SW:   word = itype(OP_SW, rs, rt, imm);
      CLS_BEQ:  word = itype(OP_BEQ, rs, rt, imm);
      CLS_ADDI: word = itype(OP_ADDI, rs, rt, imm);
      CLS_J:    word = {OP_J, target};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - descriptor stream to instruction-memory program loader
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(DEPTH);

  state_e      state, state_next;
  logic [31:0] word;
  logic        illegal;
  logic        accept, accept_legal, start_clr, full_stall;
  logic [ADDR_W+1:0] occupancy;

  mips_field_pack u_pack (
    .cls     (in_class),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

  // The in-flight write counts against capacity so the pointer can never pass DEPTH.
  assign occupancy    = {1'b0, count} + (ADDR_W+2)'(imem_we);
  assign in_ready     = (state == S_LOAD) && (occupancy < DEPTH_L);
  assign accept       = in_valid && in_ready;
  assign accept_legal = accept && !illegal;
  assign full_stall   = (state == S_LOAD) && in_valid && !in_ready;
  assign start_clr    = start && ((state == S_IDLE) || (state == S_DONE));

  // The count doubles as the write pointer; it is always below DEPTH while writing.
  assign imem_addr = count[ADDR_W-1:0];
  assign busy      = (state == S_LOAD);
  assign done      = (state == S_DONE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  if (finish) state_next = accept_legal ? S_DRAIN : S_DONE;
      S_DRAIN: state_next = S_DONE;
      S_DONE:  if (start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      imem_we     <= 1'b0;
      imem_wdata  <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      state   <= state_next;
      imem_we <= accept_legal;
      if (accept_legal) imem_wdata <= word;
      if (start_clr) begin
        count       <= '0;
        err_illegal <= 1'b0;
        err_full    <= 1'b0;
      end else begin
        if (imem_we) count <= count + 1'b1;
        if (accept && illegal) err_illegal <= 1'b1;
        if (full_stall) err_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - scoreboard bench for mips_instr_encoder
module tb_mips_instr_encoder;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n, start, finish, in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              busy, done, err_illegal, err_full;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_full(err_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.word);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  // Drives one descriptor; returns #1 after its acceptance edge.
  task automatic send(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input bit expect_write, input logic [ADDR_W-1:0] addr,
                      input logic [31:0] word, input bit with_finish);
    int n;
    exp_t e;
    in_class = cls; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    if (expect_write) begin
      e.addr = addr;
      e.word = word;
      exp_q.push_back(e);
    end
    finish = with_finish;
    tick();
    in_valid = 1'b0;
    finish   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_flags"}, {28'd0, busy, done, err_illegal, err_full}, 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_class = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // single ADD
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, 6'd0, 32'h0022_1820, 1'b0);
    check("add_we", 32'(imem_we), 32'd1);
    check("add_addr", 32'(imem_addr), 32'd0);
    check("add_wdata", imem_wdata, 32'h0022_1820);
    tick();
    check("add_count", 32'(count), 32'd1);
    check("add_we_low", 32'(imem_we), 32'd0);
    check("wdata_hold", imem_wdata, 32'h0022_1820);
    pulse_finish();
    check("done_1", 32'(done), 32'd1);

    // back-to-back LW, BEQ, J after a restart from DONE
    pulse_start();
    check("restart_count", 32'(count), 32'd0);
    send(4'd5, 5'd9, 5'd8, 5'd0, 16'h0004, 26'd0, 1'b1, 6'd0, 32'h8D28_0004, 1'b0);
    send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b1, 6'd1, 32'h1022_FFFF, 1'b0);
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1, 6'd2, 32'h0800_0010, 1'b0);
    check("j_addr_live", 32'(imem_addr), 32'd2);
    tick();
    check("b2b_count", 32'(count), 32'd3);
    pulse_finish();

    // illegal class between two ADDs
    pulse_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, 6'd0, 32'h0022_1820, 1'b0);
    send(4'd12, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 6'd0, 32'd0, 1'b0);
    check("illegal_flag", 32'(err_illegal), 32'd1);
    send(4'd0, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b1, 6'd1, 32'h0085_3020, 1'b0);
    tick();
    check("illegal_count", 32'(count), 32'd2);
    pulse_finish();
    check("illegal_sticky", 32'(err_illegal), 32'd1);

    // full: five beats held against DEPTH=4
    pulse_start();
    check("start_clears_illegal", 32'(err_illegal), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_t e;
      e.addr = ADDR_W'(i);
      e.word = 32'h0085_3020;
      exp_q.push_back(e);
    end
    in_class = 4'd0; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6; in_valid = 1'b1;
    repeat (8) tick();
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_flag", 32'(err_full), 32'd1);
    check("full_count", 32'(count), 32'd4);
    in_valid = 1'b0;
    tick();
    check("full_sticky", 32'(err_full), 32'd1);
    pulse_finish();

    // finish coinciding with the last accept
    pulse_start();
    check("start_clears_full", 32'(err_full), 32'd0);
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'h0007, 26'd0, 1'b1, 6'd0, 32'h2022_0007, 1'b1);
    check("fin_we", 32'(imem_we), 32'd1);
    check("fin_not_done_yet", 32'(done), 32'd0);
    tick();
    check("fin_done", 32'(done), 32'd1);
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_count", 32'(count), 32'd1);

    // reset right after an accept discards the pending write
    pulse_start();
    send(4'd6, 5'd3, 5'd4, 5'd0, 16'h0010, 26'd0, 1'b0, 6'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send(4'd6, 5'd3, 5'd4, 5'd0, 16'h0010, 26'd0, 1'b1, 6'd0, 32'hAC64_0010, 1'b0);
    check("post_reset_addr", 32'(imem_addr), 32'd0);
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
